// File: rtl/serv_mem_pkg.sv
// Shared types and lane/alignment helpers for the serial load/store sequencer.
package serv_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_IN,
    BUS,
    SHIFT_OUT,
    TRAP
  } state_e;

  localparam int SER_CNT_W = 5;

  // Byte-lane selects for the latched access shape.
  function automatic logic [3:0] wb_sel(input logic [1:0] lsb,
                                        input logic       word,
                                        input logic       half);
    logic [3:0] sel;
    sel[3] = (lsb == 2'd3) | word | (half & lsb[1]);
    sel[2] = (lsb == 2'd2) | word;
    sel[1] = (lsb == 2'd1) | word | (half & ~lsb[1]);
    sel[0] = (lsb == 2'd0);
    return sel;
  endfunction

  function automatic logic misalign(input logic [1:0] lsb,
                                    input logic       word,
                                    input logic       half,
                                    input logic       with_csr);
    return with_csr & ((lsb[0] & (word | half)) | (lsb[1] & word));
  endfunction

endpackage

// File: rtl/serv_mem_shreg.sv
// 32-bit serial shift / parallel-load buffer with its 5-bit serial step counter.
module serv_mem_shreg
  import serv_mem_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_shift_in,
  input  logic        i_shift_out,
  input  logic        i_rs2,
  input  logic        i_load,
  input  logic [31:0] i_load_dat,
  output logic [31:0] o_buf,
  output logic [1:0]  o_bytecnt,
  output logic        o_cnt_last
);

  logic [31:0]          buf_q;
  logic [SER_CNT_W-1:0] cnt_q;

  // NOTE: the buffer is a plain register, so it takes the synchronous reset like any other state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else if (i_load) begin
      buf_q <= i_load_dat;
      cnt_q <= '0;
    end else if (i_shift_in | i_shift_out) begin
      // Shift-out feeds zeros; the counter wraps 31->0 on the terminal step only.
      buf_q <= {i_shift_in & i_rs2, buf_q[31:1]};
      cnt_q <= cnt_q + SER_CNT_W'(1);
    end
  end

  assign o_buf      = buf_q;
  assign o_bytecnt  = cnt_q[4:3];
  assign o_cnt_last = &cnt_q;

endmodule

// File: rtl/serv_mem_seq.sv
// Load/store sequencer: serial store capture, one data-bus cycle, serial load replay.
module serv_mem_seq
  import serv_mem_pkg::*;
#(
  parameter int W        = 1,
  parameter bit WITH_CSR = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [1:0]  i_lsb,
  input  logic        i_word,
  input  logic        i_half,
  input  logic        i_cnt_en,
  input  logic        i_rs2,
  input  logic        i_dbus_ack,
  input  logic [31:0] i_dbus_rdt,
  output logic        o_busy,
  output logic        o_dbus_cyc,
  output logic        o_dbus_we,
  output logic [3:0]  o_dbus_sel,
  output logic [31:0] o_dbus_dat,
  output logic [1:0]  o_bytecnt,
  output logic        o_bufreg2_q,
  output logic        o_done,
  output logic        o_misalign_trap
);

  if (W != 1) begin : g_bad_width
    $error("serv_mem_seq: only W=1 is supported");
  end

  state_e      state_q, state_d;
  logic        we_q, word_q, half_q;
  logic [1:0]  lsb_q;
  logic        done_q, done_d;
  logic        latch;
  logic        shift_in, shift_out, load;
  logic [31:0] buf_w;
  logic [31:0] load_dat;
  logic [1:0]  bytecnt_w;
  logic        cnt_last;

  serv_mem_shreg u_shreg (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_shift_in  (shift_in),
    .i_shift_out (shift_out),
    .i_rs2       (i_rs2),
    .i_load      (load),
    .i_load_dat  (load_dat),
    .o_buf       (buf_w),
    .o_bytecnt   (bytecnt_w),
    .o_cnt_last  (cnt_last)
  );

  // Read data is right-aligned to lane 0 before serial replay.
  assign load_dat = i_dbus_rdt >> {lsb_q, 3'b000};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    latch     = 1'b0;
    shift_in  = 1'b0;
    shift_out = 1'b0;
    load      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_req) begin
          latch = 1'b1;
          if (misalign(i_lsb, i_word, i_half, WITH_CSR)) state_d = TRAP;
          else if (i_we)                                 state_d = SHIFT_IN;
          else                                           state_d = BUS;
        end
      end
      SHIFT_IN: begin
        if (i_cnt_en) begin
          shift_in = 1'b1;
          if (cnt_last) state_d = BUS;
        end
      end
      BUS: begin
        if (i_dbus_ack) begin
          if (we_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            load    = 1'b1;
            state_d = SHIFT_OUT;
          end
        end
      end
      SHIFT_OUT: begin
        if (i_cnt_en) begin
          shift_out = 1'b1;
          if (cnt_last) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      TRAP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      lsb_q   <= 2'b00;
      word_q  <= 1'b0;
      half_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (latch) begin
        we_q   <= i_we;
        lsb_q  <= i_lsb;
        word_q <= i_word;
        half_q <= i_half;
      end
    end
  end

  // Store data is rotated so byte 0 of the serial word lands on lane lsb.
  always_comb begin
    o_dbus_dat = buf_w;
    unique case (lsb_q)
      2'd0: o_dbus_dat = buf_w;
      2'd1: o_dbus_dat = {buf_w[23:0], buf_w[31:24]};
      2'd2: o_dbus_dat = {buf_w[15:0], buf_w[31:16]};
      2'd3: o_dbus_dat = {buf_w[7:0],  buf_w[31:8]};
      default: o_dbus_dat = buf_w;
    endcase
  end

  assign o_busy          = (state_q != IDLE);
  assign o_dbus_cyc      = (state_q == BUS);
  assign o_dbus_we       = (state_q == BUS) & we_q;
  assign o_dbus_sel      = (state_q == BUS) ? wb_sel(lsb_q, word_q, half_q) : 4'b0000;
  assign o_bytecnt       = (state_q == SHIFT_OUT) ? bytecnt_w : 2'b00;
  assign o_bufreg2_q     = buf_w[0];
  assign o_done          = done_q;
  assign o_misalign_trap = (state_q == TRAP);

endmodule
